// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: write/pop handshake and status bundle between a UART receiver, its byte FIFO and the consumer.
interface uart_rx_fifo_if #(
    parameter int AW = 4
);
    logic          i_wr_dv;
    logic [7:0]    i_wr_byte;
    logic          i_rd_en;
    logic          i_flush;
    logic          o_rd_dv;
    logic [7:0]    o_rd_byte;
    logic          o_empty;
    logic          o_full;
    logic [AW:0]   o_count;
    logic          o_overflow;
    modport master (
        output i_wr_dv, i_wr_byte, i_rd_en, i_flush,
        input  o_rd_dv, o_rd_byte, o_empty, o_full, o_count, o_overflow
    );
    modport slave (
        input  i_wr_dv, i_wr_byte, i_rd_en, i_flush,
        output o_rd_dv, o_rd_byte, o_empty, o_full, o_count, o_overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO behind a UART receiver with registered pop output, sticky overflow and sync flush.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input logic           i_clk,
    input logic           i_rst_n,
    uart_rx_fifo_if.slave bus
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    rd_byte;
    logic          rd_dv, overflow, empty, full, do_rd, do_wr;
    // a pop frees a slot in the same cycle, so a write while full is accepted when paired with a pop
    always_comb begin
        empty = count == '0;
        full  = count == (AW+1)'(DEPTH);
        do_rd = bus.i_rd_en && !empty && !bus.i_flush;
        do_wr = bus.i_wr_dv && (!full || do_rd) && !bus.i_flush;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_byte  <= 8'h00;
            rd_dv    <= 1'b0;
            overflow <= 1'b0;
        end else if (bus.i_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_dv    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_byte <= mem[rd_ptr];
            end
            rd_dv <= do_rd;
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
            if (bus.i_wr_dv && full && !do_rd) overflow <= 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (do_wr) mem[wr_ptr] <= bus.i_wr_byte;
    end
    assign bus.o_rd_dv    = rd_dv;
    assign bus.o_rd_byte  = rd_byte;
    assign bus.o_empty    = empty;
    assign bus.o_full     = full;
    assign bus.o_count    = count;
    assign bus.o_overflow = overflow;
endmodule
